router_fsm_ctrl: RTL

//  Control FSM for the 1x3 packet router. Sequences the packet register (header, payload, parity,

---
 rtl/router_pkg.sv | 73 +++++++
 rtl/router_fsm_ctrl_if.sv | 47 ++++
 rtl/router_fsm_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
//   Shared definitions for the 1x3 packet router (FSM, register, synchronizer
//   and FIFO blocks).
//   Contents:
//     ADDR_W          destination address width (2)
//     NUM_PORTS       number of output FIFOs (3)
//     ADDR_INVALID    header address value that selects no FIFO (2'd3)
//     fsm_state_e     3-bit control FSM state encoding (DECODE_ADDRESS=0 ..
//                     WAIT_TILL_EMPTY=7)
//     fsm_outs_t      bundle of state-decoded FSM strobes
//     port_bit()      per-FIFO flag select, 0 for the invalid address
//     decode_outputs  Moore output decode of a state
// -----------------------------------------------------------------------------
package router_pkg;

   localparam int                ADDR_W       = 2;
   localparam int                NUM_PORTS    = 3;
   localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      LOAD_PARITY        = 3'd3,
      FIFO_FULL_STATE    = 3'd4,
      LOAD_AFTER_FULL    = 3'd5,
      CHECK_PARITY_ERROR = 3'd6,
      WAIT_TILL_EMPTY    = 3'd7
   } fsm_state_e;

   typedef struct packed {
      logic detect_add;
      logic lfd_state;
      logic ld_state;
      logic laf_state;
      logic full_state;
      logic rst_int_reg;
      logic write_enb_reg;
      logic busy;
   } fsm_outs_t;

   // Selects the flag of one FIFO; address 3 maps to no FIFO and reads as 0,
   // which keeps the select in range without relying on X propagation.
   function automatic logic port_bit(input logic [NUM_PORTS-1:0] flags,
                                     input logic [ADDR_W-1:0]    addr);
      logic b;
      case (addr)
         2'd0:    b = flags[0];
         2'd1:    b = flags[1];
         2'd2:    b = flags[2];
         default: b = 1'b0;
      endcase
      return b;
   endfunction

   function automatic fsm_outs_t decode_outputs(input fsm_state_e s);
      fsm_outs_t o;
      o.detect_add    = (s == DECODE_ADDRESS);
      o.lfd_state     = (s == LOAD_FIRST_DATA);
      o.ld_state      = (s == LOAD_DATA);
      o.laf_state     = (s == LOAD_AFTER_FULL);
      o.full_state    = (s == FIFO_FULL_STATE);
      o.rst_int_reg   = (s == CHECK_PARITY_ERROR);
      o.write_enb_reg = (s == LOAD_DATA) || (s == LOAD_PARITY) ||
                        (s == LOAD_AFTER_FULL);
      // The input may only move while a header is being decoded or payload
      // is streaming; everywhere else it must hold its byte.
      o.busy          = !((s == DECODE_ADDRESS) || (s == LOAD_DATA));
      return o;
   endfunction

endpackage

// File: rtl/router_fsm_ctrl_if.sv
// -----------------------------------------------------------------------------
// router_fsm_ctrl_if
//   Handshake/status bundle between the router control FSM and its
//   surroundings (input port, packet register, FIFO select logic).
//   Modports:
//     master  : drives pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
//               parity_done, low_pkt_valid; observes the FSM strobes
//     slave   : the control FSM (router_fsm_ctrl)
//   FSM strobes: detect_add, lfd_state, ld_state, laf_state, full_state,
//                rst_int_reg, write_enb_reg, busy, drop_pkt
// -----------------------------------------------------------------------------
interface router_fsm_ctrl_if;
   import router_pkg::*;

   logic                 pkt_valid;
   logic [ADDR_W-1:0]    data_in;
   logic                 fifo_full;
   logic [NUM_PORTS-1:0] fifo_empty;
   logic [NUM_PORTS-1:0] soft_reset;
   logic                 parity_done;
   logic                 low_pkt_valid;

   logic                 detect_add;
   logic                 lfd_state;
   logic                 ld_state;
   logic                 laf_state;
   logic                 full_state;
   logic                 rst_int_reg;
   logic                 write_enb_reg;
   logic                 busy;
   logic                 drop_pkt;

   modport master (
      output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
             parity_done, low_pkt_valid,
      input  detect_add, lfd_state, ld_state, laf_state, full_state,
             rst_int_reg, write_enb_reg, busy, drop_pkt
   );

   modport slave (
      input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
             parity_done, low_pkt_valid,
      output detect_add, lfd_state, ld_state, laf_state, full_state,
             rst_int_reg, write_enb_reg, busy, drop_pkt
   );

endinterface

// File: rtl/router_fsm_ctrl.sv
// -----------------------------------------------------------------------------
// router_fsm_ctrl
//   Control FSM of the 1x3 packet router. Sequences header decode, first
//   data, payload, parity load and parity check, stalls on a full or busy
//   destination FIFO and drives the FIFO write enable.
//   Ports:
//     clk    in   single clock, rising edge
//     reset  in   asynchronous, active-high
//     bus    slave modport of router_fsm_ctrl_if (inputs: pkt_valid,
//            data_in, fifo_full, fifo_empty, soft_reset, parity_done,
//            low_pkt_valid; outputs: detect_add, lfd_state, ld_state,
//            laf_state, full_state, rst_int_reg, write_enb_reg, busy,
//            drop_pkt)
//   Parameters:
//     WAIT_TIMEOUT  cycles allowed in WAIT_TILL_EMPTY before dropping
//     CNT_W         width of the wait counter
//   Build option:
//     ROUTER_FSM_TIMEOUT_EN  when defined, a packet waiting for a non-empty
//                            FIFO is dropped after WAIT_TIMEOUT cycles and
//                            drop_pkt pulses; otherwise the wait is unbounded
//                            and drop_pkt is tied low.
//   All strobes are registered and decoded from the state being entered, so
//   they are glitch-free and valid the cycle after each transition.
// -----------------------------------------------------------------------------
module router_fsm_ctrl
   import router_pkg::*;
#(
   parameter int WAIT_TIMEOUT = 64,
   parameter int CNT_W        = $clog2(WAIT_TIMEOUT)
) (
   input  logic             clk,
   input  logic             reset,
   router_fsm_ctrl_if.slave bus
);

   if (WAIT_TIMEOUT < 2 || CNT_W < $clog2(WAIT_TIMEOUT)) begin : g_bad_timeout
      $error("router_fsm_ctrl: WAIT_TIMEOUT must be >= 2 and fit in CNT_W bits");
   end

   fsm_state_e        state_q;
   fsm_state_e        state_d;
   logic [ADDR_W-1:0] addr_q;
   fsm_outs_t         outs_q;
   logic              empty_sel;
   logic              soft_sel;

   // Flags of the FIFO the current packet is bound for.
   assign empty_sel = port_bit(bus.fifo_empty, addr_q);
   assign soft_sel  = port_bit(bus.soft_reset, addr_q);

`ifdef ROUTER_FSM_TIMEOUT_EN
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_hit;
   logic             drop_pkt_q;

   // An emptying FIFO or a soft reset on the last wait cycle takes
   // precedence, so neither is reported as a drop.
   assign timeout_hit = (state_q == WAIT_TILL_EMPTY) && !empty_sel && !soft_sel &&
                        (wait_cnt == CNT_W'(WAIT_TIMEOUT - 1));
`endif

   // NOTE: every variable driven here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DECODE_ADDRESS: begin
            if (bus.pkt_valid && bus.data_in != ADDR_INVALID) begin
               state_d = port_bit(bus.fifo_empty, bus.data_in) ? LOAD_FIRST_DATA
                                                               : WAIT_TILL_EMPTY;
            end
         end
         LOAD_FIRST_DATA: state_d = LOAD_DATA;
         LOAD_DATA: begin
            if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
            else if (!bus.pkt_valid) state_d = LOAD_PARITY;
         end
         FIFO_FULL_STATE: begin
            if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
         end
         LOAD_AFTER_FULL: begin
            if (bus.parity_done)        state_d = DECODE_ADDRESS;
            else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
            else                        state_d = LOAD_DATA;
         end
         LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR: begin
            state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
         end
         WAIT_TILL_EMPTY: begin
            if (empty_sel) state_d = LOAD_FIRST_DATA;
`ifdef ROUTER_FSM_TIMEOUT_EN
            else if (timeout_hit) state_d = DECODE_ADDRESS;
`endif
         end
      endcase
      // A read-side timeout on the destination FIFO aborts the packet from
      // any state that owns a destination.
      if (state_q != DECODE_ADDRESS && soft_sel) state_d = DECODE_ADDRESS;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= DECODE_ADDRESS;
         addr_q  <= '0;
         outs_q  <= decode_outputs(DECODE_ADDRESS);
      end else begin
         state_q <= state_d;
         outs_q  <= decode_outputs(state_d);
         if (state_q == DECODE_ADDRESS && bus.pkt_valid) addr_q <= bus.data_in;
      end
   end

`ifdef ROUTER_FSM_TIMEOUT_EN
   // Held at zero outside WAIT_TILL_EMPTY, so it starts from zero on entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt   <= '0;
         drop_pkt_q <= 1'b0;
      end else begin
         drop_pkt_q <= timeout_hit;
         if (state_q == WAIT_TILL_EMPTY) wait_cnt <= wait_cnt + CNT_W'(1);
         else                            wait_cnt <= '0;
      end
   end

   assign bus.drop_pkt = drop_pkt_q;
`else
   assign bus.drop_pkt = 1'b0;
`endif

   assign bus.detect_add    = outs_q.detect_add;
   assign bus.lfd_state     = outs_q.lfd_state;
   assign bus.ld_state      = outs_q.ld_state;
   assign bus.laf_state     = outs_q.laf_state;
   assign bus.full_state    = outs_q.full_state;
   assign bus.rst_int_reg   = outs_q.rst_int_reg;
   assign bus.write_enb_reg = outs_q.write_enb_reg;
   assign bus.busy          = outs_q.busy;

endmodule
